// File: rtl/qa_drv_prim_cf_pkg.sv
// Shared constants and helpers for the counting Bloom filter.
package qa_drv_prim_cf_pkg;

  // Widest key and widest index the hash helper supports.
  localparam int CF_KEY_MAX = 64;
  localparam int CF_IDX_MAX = 16;

  // Saturation value of a counter of the given width.
  function automatic int cf_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  // Width of the signed sum cur + up - down for one bucket.
  function automatic int cf_delta_width(input int bits, input int ports, input int hashes);
    return bits + $clog2(ports * hashes + 1) + 1;
  endfunction

  // Hash j: rotate the key left by j bits inside key_bits, then XOR-fold
  // idx_bits-wide chunks. Bits above key_bits are zero, which gives the
  // zero-padding of the last chunk.
  function automatic logic [CF_IDX_MAX-1:0] cf_hash(input logic [CF_KEY_MAX-1:0] key,
                                                    input int j,
                                                    input int key_bits,
                                                    input int idx_bits);
    logic [CF_KEY_MAX-1:0] kmask;
    logic [CF_KEY_MAX-1:0] imask;
    logic [CF_KEY_MAX-1:0] kin;
    logic [CF_KEY_MAX-1:0] rest;
    logic [CF_IDX_MAX-1:0] idx;
    kmask = {CF_KEY_MAX{1'b1}} >> (CF_KEY_MAX - key_bits);
    imask = {CF_KEY_MAX{1'b1}} >> (CF_KEY_MAX - idx_bits);
    kin   = key & kmask;
    rest  = ((kin << j) | (kin >> (key_bits - j))) & kmask;
    idx   = '0;
    for (int c = 0; c < CF_KEY_MAX / 2; c++) begin
      idx  = idx ^ CF_IDX_MAX'(rest & imask);
      rest = rest >> idx_bits;
    end
    return idx;
  endfunction

endpackage

// File: rtl/qa_drv_prim_cf_bucket.sv
// One saturating counter of the filter with net up/down update and clear.
module qa_drv_prim_cf_bucket
  import qa_drv_prim_cf_pkg::*;
#(
  parameter int BITS  = 4,
  parameter int UP_W  = 2,
  parameter int NET_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [UP_W-1:0] up,
  input  logic [UP_W-1:0] down,
  output logic [BITS-1:0] count,
  output logic [BITS-1:0] count_next,
  output logic            overflow,
  output logic            underflow
);

  localparam int MAX = cf_max(BITS);
  localparam logic signed [NET_W-1:0] MAX_S = NET_W'(MAX);

  logic signed [NET_W-1:0] net;

  // Net the increments against the decrements, then clamp into [0, MAX].
  always_comb begin
    net        = NET_W'(count) + NET_W'(up) - NET_W'(down);
    count_next = count;
    overflow   = 1'b0;
    underflow  = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (net > MAX_S) begin
      count_next = BITS'(MAX);
      overflow   = 1'b1;
    end else if (net[NET_W-1]) begin
      count_next = '0;
      underflow  = 1'b1;
    end else begin
      count_next = net[BITS-1:0];
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/qa_drv_prim_counting_filter_hashed.sv
// Multi-hash counting Bloom filter with pipelined tests, bulk clear and occupancy.
module qa_drv_prim_counting_filter_hashed
  import qa_drv_prim_cf_pkg::*;
#(
  parameter int N_BUCKETS        = 64,
  parameter int BITS_PER_BUCKET  = 4,
  parameter int KEY_BITS         = 32,
  parameter int N_HASHES         = 2,
  parameter int N_TEST_CLIENTS   = 1,
  parameter int N_INSERT_CLIENTS = 1,
  parameter int N_REMOVE_CLIENTS = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [N_TEST_CLIENTS-1:0]                   test_en,
  input  logic [N_TEST_CLIENTS-1:0][KEY_BITS-1:0]     test_key,
  output logic [N_TEST_CLIENTS-1:0]                   test_valid,
  output logic [N_TEST_CLIENTS-1:0]                   test_isZero,
  output logic [N_TEST_CLIENTS-1:0]                   test_notFull,
  input  logic [N_INSERT_CLIENTS-1:0]                 insert_en,
  input  logic [N_INSERT_CLIENTS-1:0][KEY_BITS-1:0]   insert_key,
  input  logic [N_REMOVE_CLIENTS-1:0]                 remove_en,
  input  logic [N_REMOVE_CLIENTS-1:0][KEY_BITS-1:0]   remove_key,
  input  logic                                        clear,
  output logic [$clog2(N_BUCKETS):0]                  occupancy,
  output logic                                        overflow_err,
  output logic                                        underflow_err
);

  localparam int IDX_BITS  = $clog2(N_BUCKETS);
  localparam int OCC_W     = IDX_BITS + 1;
  localparam int BITS      = BITS_PER_BUCKET;
  localparam int MAX       = cf_max(BITS);
  localparam int MAX_PORTS = (N_INSERT_CLIENTS > N_REMOVE_CLIENTS) ? N_INSERT_CLIENTS : N_REMOVE_CLIENTS;
  localparam int CNT_W     = $clog2(MAX_PORTS * N_HASHES + 1);
  localparam int NET_W     = cf_delta_width(BITS, MAX_PORTS, N_HASHES);
  // A bucket is "not full" when a worst-case cycle of inserts cannot saturate it.
  localparam int NF_LIMIT  = MAX - N_INSERT_CLIENTS * N_HASHES;
  localparam logic NF_OK   = (NF_LIMIT >= 0);
  localparam logic [BITS-1:0] NF_LIM = (NF_LIMIT >= 0) ? BITS'(NF_LIMIT) : '0;

  // Bucket index of a key under hash j.
  function automatic logic [IDX_BITS-1:0] bucket_of(input logic [KEY_BITS-1:0] key, input int j);
    logic [CF_IDX_MAX-1:0] full;
    full = cf_hash(CF_KEY_MAX'(key), j, KEY_BITS, IDX_BITS);
    return full[IDX_BITS-1:0];
  endfunction

  logic [IDX_BITS-1:0] ins_idx [N_INSERT_CLIENTS][N_HASHES];
  logic [IDX_BITS-1:0] rem_idx [N_REMOVE_CLIENTS][N_HASHES];
  logic [IDX_BITS-1:0] tst_idx [N_TEST_CLIENTS][N_HASHES];
  logic [CNT_W-1:0]    up      [N_BUCKETS];
  logic [CNT_W-1:0]    down    [N_BUCKETS];
  logic [BITS-1:0]     count   [N_BUCKETS];
  logic [BITS-1:0]     count_next [N_BUCKETS];
  logic [N_BUCKETS-1:0] ovf_vec;
  logic [N_BUCKETS-1:0] unf_vec;
  logic [N_TEST_CLIENTS-1:0] iz;
  logic [N_TEST_CLIENTS-1:0] nf;
  logic [OCC_W-1:0]    occ_next;

  // Hash every key presented this cycle.
  always_comb begin
    for (int h = 0; h < N_HASHES; h++) begin
      for (int p = 0; p < N_INSERT_CLIENTS; p++) ins_idx[p][h] = bucket_of(insert_key[p], h);
      for (int p = 0; p < N_REMOVE_CLIENTS; p++) rem_idx[p][h] = bucket_of(remove_key[p], h);
      for (int t = 0; t < N_TEST_CLIENTS; t++)   tst_idx[t][h] = bucket_of(test_key[t], h);
    end
  end

  // Count (port, hash) hits per bucket; colliding hashes each count once.
  always_comb begin
    for (int b = 0; b < N_BUCKETS; b++) begin
      up[b]   = '0;
      down[b] = '0;
    end
    for (int h = 0; h < N_HASHES; h++) begin
      for (int p = 0; p < N_INSERT_CLIENTS; p++) begin
        if (insert_en[p]) begin
          up[ins_idx[p][h]] = up[ins_idx[p][h]] + CNT_W'(1);
        end else begin
          up[ins_idx[p][h]] = up[ins_idx[p][h]];
        end
      end
      for (int p = 0; p < N_REMOVE_CLIENTS; p++) begin
        if (remove_en[p]) begin
          down[rem_idx[p][h]] = down[rem_idx[p][h]] + CNT_W'(1);
        end else begin
          down[rem_idx[p][h]] = down[rem_idx[p][h]];
        end
      end
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < N_BUCKETS; gb++) begin : g_bucket
      qa_drv_prim_cf_bucket #(
        .BITS  (BITS),
        .UP_W  (CNT_W),
        .NET_W (NET_W)
      ) u_bucket (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .up         (up[gb]),
        .down       (down[gb]),
        .count      (count[gb]),
        .count_next (count_next[gb]),
        .overflow   (ovf_vec[gb]),
        .underflow  (unf_vec[gb])
      );
    end
  endgenerate

  // Stage 0 of the test pipeline: evaluate against pre-update counters.
  always_comb begin
    for (int t = 0; t < N_TEST_CLIENTS; t++) begin
      iz[t] = 1'b0;
      nf[t] = NF_OK;
      for (int h = 0; h < N_HASHES; h++) begin
        if (count[tst_idx[t][h]] == '0) begin
          iz[t] = 1'b1;
        end else begin
          iz[t] = iz[t];
        end
        if (count[tst_idx[t][h]] > NF_LIM) begin
          nf[t] = 1'b0;
        end else begin
          nf[t] = nf[t];
        end
      end
    end
  end

  // Popcount of the counters as they will be after this edge.
  always_comb begin
    occ_next = '0;
    for (int b = 0; b < N_BUCKETS; b++) begin
      occ_next = occ_next + OCC_W'(count_next[b] != '0);
    end
  end

  // Stage 1 of the test pipeline; results are forced low when not valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      test_valid   <= '0;
      test_isZero  <= '0;
      test_notFull <= '0;
    end else begin
      test_valid   <= test_en;
      test_isZero  <= test_en & iz;
      test_notFull <= test_en & nf;
    end
  end

  // Sticky error flags and registered occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      occupancy     <= '0;
    end else if (clear) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      occupancy     <= occ_next;
    end else begin
      overflow_err  <= overflow_err | (|ovf_vec);
      underflow_err <= underflow_err | (|unf_vec);
      occupancy     <= occ_next;
    end
  end

endmodule

// File: tb/tb_qa_drv_prim_counting_filter_hashed.sv
// Randomized and directed bench with a bucket-array reference model.
module tb_qa_drv_prim_counting_filter_hashed;

  localparam int NB  = 16;
  localparam int KB  = 16;
  localparam int MAXV = 15;
  localparam int NF_TH = MAXV - 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        test_en;
  logic [15:0] test_key;
  logic        test_valid;
  logic        test_isZero;
  logic        test_notFull;
  logic        insert_en;
  logic [15:0] insert_key;
  logic        remove_en;
  logic [15:0] remove_key;
  logic        clear;
  logic [4:0]  occupancy;
  logic        overflow_err;
  logic        underflow_err;

  int cnt [NB];
  int m_ovf;
  int m_unf;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qa_drv_prim_counting_filter_hashed #(
    .N_BUCKETS (NB),
    .KEY_BITS  (KB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .test_en       (test_en),
    .test_key      (test_key),
    .test_valid    (test_valid),
    .test_isZero   (test_isZero),
    .test_notFull  (test_notFull),
    .insert_en     (insert_en),
    .insert_key    (insert_key),
    .remove_en     (remove_en),
    .remove_key    (remove_key),
    .clear         (clear),
    .occupancy     (occupancy),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Rotate a 16-bit key left by j, then XOR the four hex digits together.
  function automatic int hsh(input int key, input int j);
    int r;
    int idx;
    r = ((key * (1 << j)) + (key / (1 << (KB - j)))) % 65536;
    idx = 0;
    for (int c = 0; c < 4; c++) idx = idx ^ ((r / (1 << (4 * c))) % 16);
    return idx;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic cycle();
    int e_v, e_iz, e_nf, occ, net;
    int up [NB];
    int dn [NB];
    e_v = int'(test_en);
    e_iz = 0;
    e_nf = 0;
    if (test_en) begin
      e_iz = (cnt[hsh(test_key, 0)] == 0 || cnt[hsh(test_key, 1)] == 0) ? 1 : 0;
      e_nf = (cnt[hsh(test_key, 0)] <= NF_TH && cnt[hsh(test_key, 1)] <= NF_TH) ? 1 : 0;
    end
    for (int b = 0; b < NB; b++) begin up[b] = 0; dn[b] = 0; end
    for (int j = 0; j < 2; j++) begin
      if (insert_en) up[hsh(insert_key, j)]++;
      if (remove_en) dn[hsh(remove_key, j)]++;
    end
    @(posedge clk);
    #1;
    if (clear) begin
      model_reset();
    end else begin
      for (int b = 0; b < NB; b++) begin
        net = cnt[b] + up[b] - dn[b];
        if (net > MAXV) begin cnt[b] = MAXV; m_ovf = 1; end
        else if (net < 0) begin cnt[b] = 0; m_unf = 1; end
        else cnt[b] = net;
      end
    end
    occ = 0;
    for (int b = 0; b < NB; b++) if (cnt[b] != 0) occ++;
    check("test_valid", test_valid, e_v);
    check("test_isZero", test_isZero, e_iz);
    check("test_notFull", test_notFull, e_nf);
    check("occupancy", occupancy, occ);
    check("overflow_err", overflow_err, m_ovf);
    check("underflow_err", underflow_err, m_unf);
  endtask

  task automatic idle();
    test_en = 1'b0; insert_en = 1'b0; remove_en = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_valid", test_valid, 0);
    check("rst_isZero", test_isZero, 0);
    check("rst_notFull", test_notFull, 0);
    check("rst_occ", occupancy, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_unf", underflow_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    idle();
    test_key = 16'h0000; insert_key = 16'h0000; remove_key = 16'h0000;
    do_reset();

    // 1: empty filter
    test_en = 1'b1; test_key = 16'h0001;
    cycle();
    check("t1_isZero", test_isZero, 1);
    check("t1_notFull", test_notFull, 1);

    // 2: one insert, then positive, false-positive and negative tests
    idle(); insert_en = 1'b1; insert_key = 16'h0001;
    cycle();
    check("t2_occ", occupancy, 2);
    idle(); test_en = 1'b1; test_key = 16'h0001; cycle();
    test_key = 16'h0010; cycle();
    check("t2_false_pos", test_isZero, 0);
    test_key = 16'h0003; cycle();
    check("t2_absent", test_isZero, 1);

    // 3: drive buckets to saturation with tests every cycle
    insert_en = 1'b1; insert_key = 16'h0001; test_key = 16'h0001;
    for (int i = 0; i < 15; i++) cycle();
    idle(); test_en = 1'b1; test_key = 16'h0001; cycle();
    check("t3_ovf", overflow_err, 1);
    check("t3_notFull", test_notFull, 0);

    // 4: remove from an empty filter
    idle(); do_reset();
    remove_en = 1'b1; remove_key = 16'h0001; cycle();
    check("t4_unf", underflow_err, 1);
    check("t4_occ", occupancy, 0);

    // 5: insert+remove at MAX nets out; same-cycle test sees pre-update state
    idle(); do_reset();
    insert_en = 1'b1; insert_key = 16'h0001;
    for (int i = 0; i < 15; i++) cycle();
    remove_en = 1'b1; remove_key = 16'h0001; test_en = 1'b1; test_key = 16'h0001;
    cycle();
    check("t5_no_ovf", overflow_err, 0);
    idle(); do_reset();
    insert_en = 1'b1; insert_key = 16'h0003; test_en = 1'b1; test_key = 16'h0003;
    cycle();
    check("t5_pre_insert", test_isZero, 1);

    // 6: clear with a concurrent insert, then reset in the middle of a test
    idle(); insert_en = 1'b1; insert_key = 16'h0001; cycle(); cycle();
    insert_key = 16'h0003; clear = 1'b1; test_en = 1'b1; test_key = 16'h0003;
    cycle();
    check("t6_pre_clear", test_isZero, 0);
    check("t6_occ", occupancy, 0);
    idle(); test_en = 1'b1; test_key = 16'h0003; cycle();
    check("t6_cleared", test_isZero, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_flush", test_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle();

    // Randomized traffic over a small key pool plus full-width keys
    for (int i = 0; i < 600; i++) begin
      test_en    = ($urandom_range(0, 1) == 1);
      insert_en  = ($urandom_range(0, 9) < 6);
      remove_en  = ($urandom_range(0, 9) < 4);
      clear      = ($urandom_range(0, 39) == 0);
      test_key   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      insert_key = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      remove_key = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
